// File: rtl/key_filter.sv
// key_filter: debounces an active-low push-button into a clean level plus press/release pulses
module key_filter #(
  parameter int CNT_MAX = 1_000_000
) (
  input  logic sys_clock,
  input  logic sys_reset_n,
  input  logic key_in,
  output logic key_level,
  output logic key_flag,
  output logic key_release
);
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_FILT = 2'd1;
  localparam logic [1:0] PRESSED    = 2'd2;
  localparam logic [1:0] REL_FILT   = 2'd3;
  logic          key_s1_q, key_s2_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          flag_q, flag_d;
  logic          rel_q, rel_d;
  // Filter FSM: a new level is accepted only after CNT_MAX consecutive synchronized samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    flag_d  = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = key_s2_q ? IDLE : PRESS_FILT;
        cnt_d   = key_s2_q ? '0 : CW'(1);
      end
      PRESS_FILT: begin
        if (key_s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          level_d = 1'b0;
          flag_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        state_d = key_s2_q ? REL_FILT : PRESSED;
        cnt_d   = key_s2_q ? CW'(1) : '0;
      end
      default: begin
        if (!key_s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          level_d = 1'b1;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end
  // Two-flop synchronizer plus registered FSM state and outputs
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      level_q  <= 1'b1;
      flag_q   <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      key_s1_q <= key_in;
      key_s2_q <= key_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      flag_q   <= flag_d;
      rel_q    <= rel_d;
    end
  end
  assign key_level   = level_q;
  assign key_flag    = flag_q;
  assign key_release = rel_q;
endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: directed vectors plus a random run against a run-length debounce model
module tb_key_filter;
  localparam int CNT_MAX = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_level, key_flag, key_release;
  int n_total = 0;
  int n_pass = 0;
  logic m_s1, m_s2, m_level, m_flag, m_rel;
  int m_run;
  logic last_flag;

  key_filter #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clock(clk),
    .sys_reset_n(rst_n),
    .key_in(key_in),
    .key_level(key_level),
    .key_flag(key_flag),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Reference: level toggles once the synchronized input has differed from it for CNT_MAX straight samples
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= 1'b1;
      m_s2 <= 1'b1;
      m_level <= 1'b1;
      m_run <= 0;
      m_flag <= 1'b0;
      m_rel <= 1'b0;
    end else begin
      m_s1 <= key_in;
      m_s2 <= m_s1;
      m_flag <= 1'b0;
      m_rel <= 1'b0;
      if (m_s2 == m_level) m_run <= 0;
      else if (m_run == CNT_MAX - 1) begin
        m_run <= 0;
        m_level <= m_s2;
        m_flag <= ~m_s2;
        m_rel <= m_s2;
      end else m_run <= m_run + 1;
    end
  end

  task automatic check(input string tag, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic lvl, input logic flg, input logic rel);
    check({tag, "_level"}, key_level, lvl);
    check({tag, "_flag"}, key_flag, flg);
    check({tag, "_rel"}, key_release, rel);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      key_in = 1'($urandom_range(1));
      step();
      expect_out("reset", 1'b1, 1'b0, 1'b0);
    end
    key_in = 1'b1;
    rst_n = 1'b1;
    repeat (3) step();
    expect_out("idle", 1'b1, 1'b0, 1'b0);

    key_in = 1'b0;
    for (int i = 1; i <= 57; i++) begin
      step();
      expect_out("press", i < 7, i == 7, 1'b0);
    end
    key_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      expect_out("release", i >= 7, 1'b0, i == 7);
    end

    key_in = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 4) key_in = 1'b1;
      expect_out("bounce4", 1'b1, 1'b0, 1'b0);
    end

    key_in = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 5) key_in = 1'b1;
      expect_out("exact5", !(i >= 7 && i < 12), i == 7, i == 12);
    end

    key_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      expect_out("press2", i < 7, i == 7, 1'b0);
    end
    key_in = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 4) key_in = 1'b0;
      expect_out("relbounce", 1'b0, 1'b0, 1'b0);
    end
    key_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      expect_out("release2", i >= 7, 1'b0, i == 7);
    end

    key_in = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    expect_out("rst_filt", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      expect_out("rst_hold", 1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      expect_out("rst_fresh", i < 7, i == 7, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    expect_out("rst_pressed", 1'b1, 1'b0, 1'b0);
    key_in = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      expect_out("rst_idle", 1'b1, 1'b0, 1'b0);
    end

    last_flag = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) == 0) key_in = ~key_in;
      repeat (2) begin
        step();
        expect_out("rand", m_level, m_flag, m_rel);
        check("rand_excl", key_flag & key_release, 1'b0);
        if (key_flag) begin
          check("rand_alt_flag", last_flag, 1'b0);
          last_flag = 1'b1;
        end
        if (key_release) begin
          check("rand_alt_rel", last_flag, 1'b1);
          last_flag = 1'b0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Debounces a raw mechanical push-button (`key_in`, active-low, idle high).
- Emits a clean debounced level plus one-cycle press and release pulses.
- Sits between the board key pin and downstream registered consumers such as the key-to-LED register, which take `key_flag`/`key_level` instead of raw `key_in`.
- Runs on `sys_clock`, nominally 50 MHz.

Parameters:
- CNT_MAX, default 1_000_000: consecutive synchronized samples at the new level needed to accept a transition (20 ms at 50 MHz). Legal range is CNT_MAX >= 2.
- Counter width is $clog2(CNT_MAX)+1 bits, internal only.

Ports:
- sys_clock  input  1  system clock; all logic on its rising edge.
- sys_reset_n  input  1  asynchronous, active-low reset.
- key_in  input  1  raw button pin, asynchronous to sys_clock; 0 = pressed.
- key_level  output  1  debounced level; 1 = released, 0 = pressed.
- key_flag  output  1  one-cycle pulse on each accepted press.
- key_release  output  1  one-cycle pulse on each accepted release.

Behaviour:
- Reset (async assert, sync release by clock domain): state = IDLE, cnt = 0, sync flops key_s1/key_s2 = 1, key_level = 1, key_flag = 0, key_release = 0.
- Synchronizer: key_s1 <= key_in; key_s2 <= key_s1. Only key_s2 feeds the FSM.
- All outputs are registered. key_flag and key_release default to 0 every cycle unless set below.
- IDLE (stable released, key_level = 1):
  - key_s2 = 0: go to PRESS_FILT, cnt <= 1 (first low sample).
  - Otherwise stay in IDLE, cnt <= 0.
- PRESS_FILT:
  - key_s2 = 1 (bounce): return to IDLE, cnt <= 0, no pulse.
  - key_s2 = 0 and cnt = CNT_MAX-1: go to PRESSED, key_level <= 0, key_flag <= 1, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- PRESSED (stable pressed, key_level = 0):
  - key_s2 = 1: go to REL_FILT, cnt <= 1.
  - Otherwise stay.
- REL_FILT:
  - key_s2 = 0 (bounce): return to PRESSED, cnt <= 0.
  - key_s2 = 1 and cnt = CNT_MAX-1: go to IDLE, key_level <= 1, key_release <= 1, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- Latency:
  - Edge 0 is the first rising edge at which key_in is sampled low and held.
  - key_s2 is first low after edge 1.
  - Acceptance happens on edge CNT_MAX+1, so key_flag is high for exactly the cycle after edge CNT_MAX+1.
  - key_level falls on the same edge.
  - Release has identical latency.
- Exact boundary: a glitch lasting CNT_MAX-1 samples is rejected. A glitch lasting exactly CNT_MAX samples is accepted.
- The counter never exceeds CNT_MAX-1 and never wraps. No pulse is emitted while held; at most one key_flag per press.
- key_flag and key_release are never high in the same cycle. A key_release always follows a key_flag before the next key_flag.
- Reset mid-filter or while pressed: immediate return to reset values with no pulses.
  - If the key is still held low after reset release, it is detected as a fresh press with full latency.
- X/metastability on key_in is tolerated by the 2-flop synchronizer; key_s2 is never X after the first post-reset edges.

Test Plan:
- Reset check: hold sys_reset_n = 0 with key_in toggling randomly -> key_level = 1 and key_flag = key_release = 0 throughout.
- Clean press (CNT_MAX = 5): drive key_in low before edge 0 and hold -> key_level falls and key_flag is high for exactly one cycle after edge 6. No further flags for 50 cycles of holding.
- Bounce rejection (CNT_MAX = 5): key_in low for 4 samples, high for 1, then high for 20 -> key_flag never asserts and key_level stays 1. Repeat with exactly 5 low samples -> one key_flag.
- Release (CNT_MAX = 5): from PRESSED, drive key_in high and hold -> key_release is a one-cycle pulse after edge 6 and key_level returns to 1. Bouncing 4-sample releases are ignored.
- Reset mid-operation (CNT_MAX = 5): assert sys_reset_n = 0 at filter cnt = 3 with key_in still low, release after 2 cycles -> outputs return to reset values immediately. A fresh key_flag appears 7 edges after reset release.
- Random stimulus: change key_in every 20 ns randomly for 10 µs (CNT_MAX = 5) -> scoreboard model matches key_level every cycle, and key_flag/key_release pulses alternate strictly.
